// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single byte-wide RAM port between ICache word fetches
// and LSB loads/stores, turning each request into a sequence of byte accesses.
module mem_arbiter #(
  parameter logic [1:0] IO_SEL_HI = 2'b11
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        flush_signal,
  input  logic        icache_req_en,
  input  logic [31:0] icache_req_addr,
  output logic        icache_done,
  output logic [31:0] icache_data,
  input  logic        lsb_req_en,
  input  logic        lsb_req_wr,
  input  logic [1:0]  lsb_req_size,
  input  logic [31:0] lsb_req_addr,
  input  logic [31:0] lsb_req_data,
  output logic        lsb_done,
  output logic [31:0] lsb_data,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full
);

  typedef enum logic [1:0] {IDLE, IFETCH, LREAD, LWRITE} state_t;

  state_t      state, state_nx;
  logic [2:0]  k, k_nx;
  logic [2:0]  n, n_nx;
  logic [31:0] addr, addr_nx;
  logic [31:0] data, data_nx;
  logic [31:0] rd_buf, rd_buf_nx;
  logic        last_lsb, last_lsb_nx;
  logic [31:0] mem_a_nx;
  logic [7:0]  mem_dout_nx;
  logic        mem_wr_nx;
  logic        icache_done_nx, lsb_done_nx;
  logic [31:0] icache_data_nx, lsb_data_nx;

  logic        ic_valid, lsb_valid;
  logic [2:0]  lsb_n;
  logic        req_io_stall, cur_io_stall;
  logic [4:0]  lane;

  // A requester whose done is still high is holding a stale request.
  assign ic_valid     = icache_req_en && !icache_done;
  assign lsb_valid    = lsb_req_en && !lsb_done;
  assign lsb_n        = (lsb_req_size == 2'd0) ? 3'd1 :
                        (lsb_req_size == 2'd1) ? 3'd2 : 3'd4;
  assign req_io_stall = (lsb_req_addr[17:16] == IO_SEL_HI) && io_buffer_full;
  assign cur_io_stall = (addr[17:16] == IO_SEL_HI) && io_buffer_full;
  assign lane         = {k[1:0], 3'b000};

  always_comb begin
    state_nx       = state;
    k_nx           = k;
    n_nx           = n;
    addr_nx        = addr;
    data_nx        = data;
    rd_buf_nx      = rd_buf;
    last_lsb_nx    = last_lsb;
    mem_a_nx       = mem_a;
    mem_dout_nx    = mem_dout;
    mem_wr_nx      = 1'b0;
    icache_done_nx = 1'b0;
    lsb_done_nx    = 1'b0;
    icache_data_nx = icache_data;
    lsb_data_nx    = lsb_data;
    if (!rdy_in) begin
      icache_done_nx = icache_done;
      lsb_done_nx    = lsb_done;
    end else begin
      case (state)
        IDLE: begin
          if (!flush_signal && (ic_valid || lsb_valid)) begin
            rd_buf_nx = '0;
            k_nx      = 3'd0;
            if (ic_valid && (!lsb_valid || last_lsb)) begin
              state_nx    = IFETCH;
              last_lsb_nx = 1'b0;
              addr_nx     = icache_req_addr;
              n_nx        = 3'd4;
              mem_a_nx    = icache_req_addr;
            end else begin
              last_lsb_nx = 1'b1;
              addr_nx     = lsb_req_addr;
              data_nx     = lsb_req_data;
              n_nx        = lsb_n;
              if (!lsb_req_wr) begin
                state_nx = LREAD;
                mem_a_nx = lsb_req_addr;
              end else begin
                // The first store byte goes out on the grant edge unless IO is full.
                state_nx = LWRITE;
                if (!req_io_stall) begin
                  mem_a_nx    = lsb_req_addr;
                  mem_dout_nx = lsb_req_data[7:0];
                  mem_wr_nx   = 1'b1;
                  k_nx        = 3'd1;
                end
              end
            end
          end
        end
        IFETCH, LREAD: begin
          if (flush_signal) begin
            state_nx = IDLE;
            k_nx     = 3'd0;
          end else begin
            rd_buf_nx[lane +: 8] = mem_din;
            if (k == n - 3'd1) begin
              state_nx = IDLE;
              k_nx     = 3'd0;
              if (state == IFETCH) begin
                icache_done_nx = 1'b1;
                icache_data_nx = rd_buf_nx;
              end else begin
                lsb_done_nx = 1'b1;
                lsb_data_nx = rd_buf_nx;
              end
            end else begin
              k_nx     = k + 3'd1;
              mem_a_nx = addr + {29'd0, k + 3'd1};
            end
          end
        end
        LWRITE: begin
          // Here k counts bytes already driven; flush never aborts a store.
          if (k == n) begin
            state_nx    = IDLE;
            k_nx        = 3'd0;
            lsb_done_nx = 1'b1;
          end else if (!cur_io_stall) begin
            mem_a_nx    = addr + {29'd0, k};
            mem_dout_nx = data[lane +: 8];
            mem_wr_nx   = 1'b1;
            k_nx        = k + 3'd1;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state       <= IDLE;
      k           <= 3'd0;
      n           <= 3'd0;
      addr        <= '0;
      data        <= '0;
      rd_buf      <= '0;
      last_lsb    <= 1'b1;
      mem_a       <= '0;
      mem_dout    <= '0;
      mem_wr      <= 1'b0;
      icache_done <= 1'b0;
      icache_data <= '0;
      lsb_done    <= 1'b0;
      lsb_data    <= '0;
    end else begin
      state       <= state_nx;
      k           <= k_nx;
      n           <= n_nx;
      addr        <= addr_nx;
      data        <= data_nx;
      rd_buf      <= rd_buf_nx;
      last_lsb    <= last_lsb_nx;
      mem_a       <= mem_a_nx;
      mem_dout    <= mem_dout_nx;
      mem_wr      <= mem_wr_nx;
      icache_done <= icache_done_nx;
      icache_data <= icache_data_nx;
      lsb_done    <= lsb_done_nx;
      lsb_data    <= lsb_data_nx;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: drives ICache/LSB traffic into mem_arbiter against a byte RAM
// model and checks data, latency, arbitration order and store side effects.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        flush_signal;
  logic        icache_req_en;
  logic [31:0] icache_req_addr;
  logic        icache_done;
  logic [31:0] icache_data;
  logic        lsb_req_en;
  logic        lsb_req_wr;
  logic [1:0]  lsb_req_size;
  logic [31:0] lsb_req_addr;
  logic [31:0] lsb_req_data;
  logic        lsb_done;
  logic [31:0] lsb_data;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;

  int checks = 0;
  int errors = 0;
  bit lastLsbModel = 1'b1;

  logic [7:0] ram [logic [31:0]];

  mem_arbiter dut (
    .clk_in(clk), .rst_in(rst_in), .rdy_in(rdy_in), .flush_signal(flush_signal),
    .icache_req_en(icache_req_en), .icache_req_addr(icache_req_addr),
    .icache_done(icache_done), .icache_data(icache_data),
    .lsb_req_en(lsb_req_en), .lsb_req_wr(lsb_req_wr), .lsb_req_size(lsb_req_size),
    .lsb_req_addr(lsb_req_addr), .lsb_req_data(lsb_req_data),
    .lsb_done(lsb_done), .lsb_data(lsb_data),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ramRead(input logic [31:0] a);
    if (ram.exists(a)) return ram[a];
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  function automatic logic [31:0] expRead(input logic [31:0] a, input int nb);
    logic [31:0] w;
    w = '0;
    for (int i = 0; i < nb; i++) w[8*i +: 8] = ramRead(a + 32'(i));
    return w;
  endfunction

  // RAM answers the address held during the cycle; writes land mid-cycle.
  always @(negedge clk) begin
    if (mem_wr === 1'b1) ram[mem_a] = mem_dout;
    mem_din = ramRead(mem_a);
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic stepEdge();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_mem_a"}, mem_a, 32'h0);
    checkOutput({tag, "_mem_dout"}, {24'b0, mem_dout}, 32'h0);
    checkOutput({tag, "_mem_wr"}, {31'b0, mem_wr}, 32'h0);
    checkOutput({tag, "_icache_done"}, {31'b0, icache_done}, 32'h0);
    checkOutput({tag, "_icache_data"}, icache_data, 32'h0);
    checkOutput({tag, "_lsb_done"}, {31'b0, lsb_done}, 32'h0);
    checkOutput({tag, "_lsb_data"}, lsb_data, 32'h0);
  endtask

  // One ICache and/or LSB transaction; requesters drop req one cycle after done.
  task automatic applyStimulus(input bit doIc, input logic [31:0] icAddr, input bit doLs,
                               input bit lsWr, input logic [1:0] lsSize, input logic [31:0] lsAddr,
                               input logic [31:0] lsData, input int flushEdge, input string tag);
    int nLs, icExpEdge, lsExpEdge, icEdge, lsEdge, icCnt, lsCnt, wrCnt, lastEdge;
    bit icFirst, icDrop, lsDrop;
    logic [31:0] icExp, lsExp;
    logic [7:0] pre [4];
    logic [7:0] expByte;
    nLs = (lsSize == 2'd0) ? 1 : (lsSize == 2'd1) ? 2 : 4;
    icExp = expRead(icAddr, 4);
    lsExp = expRead(lsAddr, nLs);
    for (int i = 0; i < 4; i++) pre[i] = ramRead(lsAddr + 32'(i));
    icFirst = doIc && (!doLs || lastLsbModel);
    if (icFirst) begin
      icExpEdge = 5;
      lsExpEdge = 5 + 1 + nLs;
    end else begin
      lsExpEdge = 1 + nLs;
      icExpEdge = lsExpEdge + 1 + 4;
    end
    if (doIc && doLs) lastLsbModel = icFirst;
    else if (doIc) lastLsbModel = 1'b0;
    else if (doLs) lastLsbModel = 1'b1;
    lastEdge = 0;
    if (doIc && icExpEdge > lastEdge) lastEdge = icExpEdge;
    if (doLs && lsExpEdge > lastEdge) lastEdge = lsExpEdge;
    lastEdge += 3;
    icache_req_addr = icAddr;
    icache_req_en   = doIc;
    lsb_req_addr    = lsAddr;
    lsb_req_wr      = lsWr;
    lsb_req_size    = lsSize;
    lsb_req_data    = lsData;
    lsb_req_en      = doLs;
    flush_signal    = (flushEdge == 1);
    icEdge = -1; lsEdge = -1; icCnt = 0; lsCnt = 0; wrCnt = 0; icDrop = 0; lsDrop = 0;
    for (int e = 1; e <= lastEdge; e++) begin
      stepEdge();
      flush_signal = (e + 1 == flushEdge);
      if (mem_wr) wrCnt++;
      if (icDrop) begin icache_req_en = 1'b0; icDrop = 0; end
      if (lsDrop) begin lsb_req_en = 1'b0; lsDrop = 0; end
      if (icache_done) begin
        icCnt++;
        if (icEdge < 0) begin
          icEdge = e;
          icDrop = 1;
          checkOutput({tag, "_icache_data"}, icache_data, icExp);
        end
      end
      if (lsb_done) begin
        lsCnt++;
        if (lsEdge < 0) begin
          lsEdge = e;
          lsDrop = 1;
          if (!lsWr) checkOutput({tag, "_lsb_data"}, lsb_data, lsExp);
        end
      end
    end
    icache_req_en = 1'b0;
    lsb_req_en    = 1'b0;
    flush_signal  = 1'b0;
    checkOutput({tag, "_icache_done_count"}, icCnt, doIc ? 1 : 0);
    checkOutput({tag, "_lsb_done_count"}, lsCnt, doLs ? 1 : 0);
    if (doIc) checkOutput({tag, "_icache_latency"}, icEdge, icExpEdge);
    if (doLs) checkOutput({tag, "_lsb_latency"}, lsEdge, lsExpEdge);
    checkOutput({tag, "_write_cycles"}, wrCnt, (doLs && lsWr) ? nLs : 0);
    if (doLs && lsWr) begin
      for (int i = 0; i < 4; i++) begin
        expByte = (i < nLs) ? lsData[8*i +: 8] : pre[i];
        checkOutput($sformatf("%s_ram_byte%0d", tag, i), {24'b0, ramRead(lsAddr + 32'(i))}, {24'b0, expByte});
      end
    end
  endtask

  task automatic dirIfetch();
    int cnt;
    ram[32'h100] = 8'h13; ram[32'h101] = 8'h00; ram[32'h102] = 8'h50; ram[32'h103] = 8'h00;
    icache_req_addr = 32'h100;
    icache_req_en   = 1'b1;
    cnt = 0;
    for (int e = 1; e <= 8; e++) begin
      stepEdge();
      if (e <= 4) checkOutput($sformatf("ifetch_mem_a_e%0d", e), mem_a, 32'h100 + 32'(e - 1));
      if (e == 5) begin
        checkOutput("ifetch_done_at_e5", {31'b0, icache_done}, 32'h1);
        checkOutput("ifetch_data", icache_data, 32'h0050_0013);
      end
      if (e == 6) icache_req_en = 1'b0;
      if (icache_done) cnt++;
    end
    checkOutput("ifetch_done_pulses", cnt, 1);
    lastLsbModel = 1'b0;
  endtask

  task automatic resetMidIfetch();
    int cnt;
    icache_req_addr = 32'h200;
    icache_req_en   = 1'b1;
    stepEdge();
    stepEdge();
    rst_in        = 1'b0;
    icache_req_en = 1'b0;
    cnt = 0;
    for (int e = 0; e < 3; e++) begin
      stepEdge();
      if (icache_done) cnt++;
    end
    checkResetOutputs("reset_mid");
    checkOutput("reset_mid_no_done", cnt, 0);
    rst_in = 1'b1;
    lastLsbModel = 1'b1;
  endtask

  task automatic ioStore();
    int cnt;
    logic [7:0] untouched;
    untouched = ramRead(32'h3_0002);
    io_buffer_full = 1'b1;
    lsb_req_addr = 32'h3_0000; lsb_req_wr = 1'b1; lsb_req_size = 2'd1;
    lsb_req_data = 32'h0000_ABCD; lsb_req_en = 1'b1;
    cnt = 0;
    for (int e = 1; e <= 8; e++) begin
      stepEdge();
      if (e <= 2) checkOutput($sformatf("io_stall_mem_wr_e%0d", e), {31'b0, mem_wr}, 32'h0);
      if (e == 2) io_buffer_full = 1'b0;
      if (e == 3) begin
        checkOutput("io_byte0_wr", {31'b0, mem_wr}, 32'h1);
        checkOutput("io_byte0_a", mem_a, 32'h3_0000);
        checkOutput("io_byte0_dout", {24'b0, mem_dout}, 32'hCD);
      end
      if (e == 4) begin
        checkOutput("io_byte1_wr", {31'b0, mem_wr}, 32'h1);
        checkOutput("io_byte1_a", mem_a, 32'h3_0001);
        checkOutput("io_byte1_dout", {24'b0, mem_dout}, 32'hAB);
      end
      if (e == 5) checkOutput("io_done_at_e5", {31'b0, lsb_done}, 32'h1);
      if (e == 6) lsb_req_en = 1'b0;
      if (lsb_done) cnt++;
    end
    checkOutput("io_done_pulses", cnt, 1);
    checkOutput("io_ram_3_0002_untouched", {24'b0, ramRead(32'h3_0002)}, {24'b0, untouched});
    lastLsbModel = 1'b1;
  endtask

  task automatic flushIfetch();
    int cnt;
    icache_req_addr = 32'h1240;
    icache_req_en   = 1'b1;
    for (int e = 1; e <= 3; e++) stepEdge();
    flush_signal  = 1'b1;
    icache_req_en = 1'b0;
    cnt = 0;
    for (int e = 4; e <= 10; e++) begin
      stepEdge();
      flush_signal = 1'b0;
      if (icache_done) cnt++;
    end
    checkOutput("flush_ifetch_no_done", cnt, 0);
    lastLsbModel = 1'b0;
  endtask

  task automatic pauseLoad();
    logic [31:0] a, exp;
    int active, doneEdge, cnt, held;
    bit drop;
    a = 32'h0000_5550;
    exp = expRead(a, 4);
    lsb_req_addr = a; lsb_req_wr = 1'b0; lsb_req_size = 2'd2; lsb_req_en = 1'b1;
    active = 0; doneEdge = -1; cnt = 0; drop = 0;
    for (int e = 1; e <= 14; e++) begin
      stepEdge();
      if (!(e >= 3 && e <= 6)) active++;
      if (e <= 8) begin
        held = (active - 1 < 3) ? active - 1 : 3;
        checkOutput($sformatf("pause_mem_a_e%0d", e), mem_a, a + 32'(held));
        if (e >= 3 && e <= 6) checkOutput($sformatf("pause_mem_wr_e%0d", e), {31'b0, mem_wr}, 32'h0);
      end
      rdy_in = !((e + 1) >= 3 && (e + 1) <= 6);
      if (drop) begin lsb_req_en = 1'b0; drop = 0; end
      if (lsb_done) begin
        cnt++;
        if (doneEdge < 0) begin
          doneEdge = e;
          drop = 1;
          checkOutput("pause_lsb_data", lsb_data, exp);
        end
      end
    end
    rdy_in = 1'b1;
    lsb_req_en = 1'b0;
    checkOutput("pause_latency", doneEdge, 9);
    checkOutput("pause_done_pulses", cnt, 1);
    lastLsbModel = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int kind;
    logic [31:0] icA, lsA, lsD;
    bit lsW;
    logic [1:0] lsS;
    rst_in = 1'b0; rdy_in = 1'b1; flush_signal = 1'b0; io_buffer_full = 1'b0;
    icache_req_en = 1'b0; icache_req_addr = '0;
    lsb_req_en = 1'b0; lsb_req_wr = 1'b0; lsb_req_size = '0; lsb_req_addr = '0; lsb_req_data = '0;
    mem_din = '0;
    stepEdge();
    stepEdge();
    checkResetOutputs("reset");
    rst_in = 1'b1;
    stepEdge();

    dirIfetch();
    resetMidIfetch();
    applyStimulus(1, 32'h200, 0, 0, 2'd0, 32'h0, 32'h0, 0, "post_reset_ifetch");
    applyStimulus(1, 32'h1_0400, 1, 0, 2'd2, 32'h0600, 32'h0, 0, "tie1");
    applyStimulus(1, 32'h1_0410, 1, 1, 2'd2, 32'h0610, 32'hDEAD_BEEF, 0, "tie2");
    applyStimulus(1, 32'h1_0420, 1, 0, 2'd1, 32'h0610, 32'h0, 0, "tie3");
    ioStore();
    flushIfetch();
    applyStimulus(0, 32'h0, 1, 0, 2'd0, 32'h0700, 32'h0, 0, "after_flush_load");
    applyStimulus(0, 32'h0, 1, 1, 2'd2, 32'h4400, 32'h1122_3344, 3, "flush_store");
    pauseLoad();
    applyStimulus(1, 32'hFFFF_FFFE, 0, 0, 2'd0, 32'h0, 32'h0, 0, "wrap_ifetch");
    applyStimulus(0, 32'h0, 1, 1, 2'd1, 32'hFFFF_FFFF, 32'h0000_9A7B, 0, "wrap_store");
    applyStimulus(0, 32'h0, 1, 0, 2'd3, 32'hFFFF_FFFF, 32'h0, 0, "size3_load");

    for (int it = 0; it < 24; it++) begin
      kind = $urandom_range(0, 2);
      icA  = 32'h0001_0000 | ($urandom & 32'h0000_FFFF);
      lsA  = $urandom & 32'h0000_7FFF;
      lsW  = 1'($urandom_range(0, 1));
      lsS  = 2'($urandom_range(0, 3));
      lsD  = $urandom;
      io_buffer_full = 1'($urandom_range(0, 1));
      applyStimulus(kind != 1, icA, kind != 0, lsW, lsS, lsA, lsD, 0, $sformatf("rnd%0d", it));
      io_buffer_full = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
